// File: rtl/sample_accumulator_pkg.sv
// Shared constants for the sample accumulator stage of the send path.
// Holds the accumulator FSM state encodings used by sample_accumulator.
package sample_accumulator_pkg;

    // Accumulator FSM states. The numeric encodings are fixed so that other
    // blocks on the send path can decode this FSM consistently.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/sample_accumulator.sv
// Windowed sample accumulator feeding the send FSM.
// While sum_en is high it sums 2**N_LOG2 accepted samples. It then latches
// the sum and the truncating average and pulses sum_ready for one cycle.
// sum_out/avg_out hold until the next completed window or reset.
module sample_accumulator
    import sample_accumulator_pkg::*;
#(
    parameter  int DATA_W = 12,
    parameter  int N_LOG2 = 4,
    localparam int OUT_W  = DATA_W + N_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sum_en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              sample_ready,
    output logic              sum_ready,
    output logic [OUT_W-1:0]  sum_out,
    output logic [DATA_W-1:0] avg_out,
    output logic              sample_dropped
);

    // One extra bit keeps the count range clear of wrap-around; the window
    // ends on the accept seen while cnt holds its last in-window value.
    localparam int              CNT_W    = N_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** N_LOG2) - 1);

    acc_state_t        state_q, state_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  sum_out_d;
    logic              sum_ready_d;
    logic              dropped_d;

    // Samples are only taken while accumulating.
    assign sample_ready = (state_q == ST_ACCUM);

    // The average is the sum with the window-size bits shifted away.
    assign avg_out = sum_out[OUT_W-1:N_LOG2];

    // Next-state, accumulator, counter and output-pulse decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = ST_IDLE;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_out_d   = sum_out;
        sum_ready_d = 1'b0;
        dropped_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = sum_en ? ST_ACCUM : ST_IDLE;
            end

            ST_ACCUM: begin
                if (!sum_en) begin
                    // Abort: partial window discarded, latched result kept.
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ACCUM;
                    if (sample_valid) begin
                        if (cnt_q == LAST_CNT) begin
                            sum_out_d   = acc_q + OUT_W'(sample);
                            sum_ready_d = 1'b1;
                            state_d     = ST_DONE;
                            acc_d       = '0;
                            cnt_d       = '0;
                        end else begin
                            acc_d = acc_q + OUT_W'(sample);
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                // The one-cycle bubble cannot take a sample; flag any that arrives.
                dropped_d = sample_valid;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = sum_en ? ST_ACCUM : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: every register here, including the latched result, is cleared
        // by reset so a mid-window reset leaves no trace of the old window.
        if (reset) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            sum_out        <= '0;
            sum_ready      <= 1'b0;
            sample_dropped <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from values computed before the edge.
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            sum_out        <= sum_out_d;
            sum_ready      <= sum_ready_d;
            sample_dropped <= dropped_d;
        end
    end

endmodule

// File: tb/tb_sample_accumulator.sv
// Self-checking bench for sample_accumulator with DATA_W=12, N_LOG2=2.
// Stimulus pushes hand-computed window results into a queue; a monitor
// pops and compares whenever the DUT pulses sum_ready.
module tb_sample_accumulator;

    localparam int DATA_W = 12;
    localparam int N_LOG2 = 2;
    localparam int OUT_W  = DATA_W + N_LOG2;

    typedef struct packed {
        logic [OUT_W-1:0]  sum;
        logic [DATA_W-1:0] avg;
    } win_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              sum_en;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              sample_ready;
    logic              sum_ready;
    logic [OUT_W-1:0]  sum_out;
    logic [DATA_W-1:0] avg_out;
    logic              sample_dropped;

    int   n_checks        = 0;
    int   n_pass          = 0;
    int   windows_pushed  = 0;
    int   windows_seen    = 0;
    int   drops_seen      = 0;
    int   drops_expected  = 0;
    win_t exp_q[$];
    logic [OUT_W-1:0] hold_sum = '0;
    bit   stab_en         = 1'b0;
    logic rst_q           = 1'b0;

    sample_accumulator #(
        .DATA_W(DATA_W),
        .N_LOG2(N_LOG2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sum_en        (sum_en),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .sample_ready  (sample_ready),
        .sum_ready     (sum_ready),
        .sum_out       (sum_out),
        .avg_out       (avg_out),
        .sample_dropped(sample_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    task automatic expect_window(input logic [OUT_W-1:0] s, input logic [DATA_W-1:0] a);
        exp_q.push_back('{sum: s, avg: a});
        windows_pushed++;
    endtask

    // Offer one sample only once the DUT is accumulating, hold it for one edge.
    task automatic push_sample(input logic [DATA_W-1:0] v);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (sample_ready === 1'b1) begin
                sample_valid = 1'b1;
                sample       = v;
                @(negedge clk);
                sample_valid = 1'b0;
                return;
            end
        end
        fail("push_timeout", "sample_ready never rose");
    endtask

    // Remember whether the last edge was a reset edge.
    always @(posedge clk) rst_q <= reset;

    // Monitor: scoreboard pop on sum_ready, drop counting, hold check.
    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            if (rst_q) hold_sum = '0;
            if (sum_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_sum_ready", $sformatf("sum_out=%0d with no window pending", sum_out));
                end else begin
                    e = exp_q.pop_front();
                    check("sum_out", 32'(sum_out), 32'(e.sum));
                    check("avg_out", 32'(avg_out), 32'(e.avg));
                    hold_sum = e.sum;
                    windows_seen++;
                end
            end
            if (sample_dropped === 1'b1) drops_seen++;
            if (stab_en) check("sum_out_hold", 32'(sum_out), 32'(hold_sum));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held three cycles with random inputs.
        reset        = 1'b1;
        sum_en       = 1'($urandom_range(1));
        sample_valid = 1'($urandom_range(1));
        sample       = DATA_W'($urandom_range(4095));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_sum_ready", 32'(sum_ready), 0);
            check("rst_sum_out", 32'(sum_out), 0);
            check("rst_sample_ready", 32'(sample_ready), 0);
            check("rst_sample_dropped", 32'(sample_dropped), 0);
            sum_en       = 1'($urandom_range(1));
            sample_valid = 1'($urandom_range(1));
            sample       = DATA_W'($urandom_range(4095));
        end
        reset        = 1'b0;
        sum_en       = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        stab_en      = 1'b1;

        // 2: samples 1,2,3,4 with gaps -> 10 / 2, one cycle after the 4th.
        push_sample(12'd1);
        @(negedge clk);
        push_sample(12'd2);
        push_sample(12'd3);
        @(negedge clk);
        @(negedge clk);
        expect_window(14'd10, 12'd2);
        push_sample(12'd4);
        check("latency_sum_ready", 32'(sum_ready), 1);
        @(negedge clk);
        check("pulse_width", 32'(sum_ready), 0);

        // 3: full-scale window -> 16380 / 4095.
        push_sample(12'd4095);
        push_sample(12'd4095);
        push_sample(12'd4095);
        expect_window(14'd16380, 12'd4095);
        push_sample(12'd4095);

        // 4: a 10-window, then abort after two 7s, then a window of 5s.
        push_sample(12'd1);
        push_sample(12'd2);
        push_sample(12'd3);
        expect_window(14'd10, 12'd2);
        push_sample(12'd4);
        push_sample(12'd7);
        push_sample(12'd7);
        sum_en = 1'b0;
        @(negedge clk);
        check("abort_sum_out", 32'(sum_out), 10);
        check("abort_sample_ready", 32'(sample_ready), 0);
        sum_en = 1'b1;
        push_sample(12'd5);
        push_sample(12'd5);
        push_sample(12'd5);
        expect_window(14'd20, 12'd5);
        push_sample(12'd5);

        // 5: sample_valid every cycle with 1..10; 5 and 10 land in DONE.
        sum_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sum_en = 1'b1;
        @(negedge clk);
        check("b2b_ready", 32'(sample_ready), 1);
        expect_window(14'd10, 12'd2);
        expect_window(14'd30, 12'd7);
        drops_expected += 2;
        for (int v = 1; v <= 10; v++) begin
            if (v > 1) @(negedge clk);
            sample_valid = 1'b1;
            sample       = DATA_W'(v);
        end
        @(negedge clk);
        sample_valid = 1'b0;

        // 6: reset mid-window after three samples, then a window of 1s.
        push_sample(12'd9);
        push_sample(12'd9);
        push_sample(12'd9);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_sum_out", 32'(sum_out), 0);
        check("midrst_avg_out", 32'(avg_out), 0);
        check("midrst_sample_ready", 32'(sample_ready), 0);
        check("midrst_sum_ready", 32'(sum_ready), 0);
        reset = 1'b0;
        push_sample(12'd1);
        push_sample(12'd1);
        push_sample(12'd1);
        expect_window(14'd4, 12'd1);
        push_sample(12'd1);

        // Drain and reconcile totals.
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        check("windows_seen", 32'(windows_seen), 32'(windows_pushed));
        check("queue_empty", 32'(exp_q.size()), 0);
        check("drops_seen", 32'(drops_seen), 32'(drops_expected));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
